tiny_fir_tap_sequencer: RTL
===========================

Name: tiny_fir_tap_sequencer

Overview:
Controller that configures and sequences one tiny_fir instance. It loads one of G_NUM_SETS coefficient sets from an external coefficient memory into the FIR's tap port. It drains in-flight samples before a reload and gates the sample stream so no sample is processed against a partially loaded tap set. Sample data bypasses this block; only valid/ready and fir_enable are controlled here.

Parameters:
G_NUM_TAPS, 16, taps per coefficient set
G_TAP_WIDTH, 16, tap width in bits
G_NUM_SETS, 4, number of coefficient sets in coefficient memory
G_MAX_INFLIGHT, 4, max samples accepted by FIR but not yet output
G_DONE_TIMEOUT, 64, cycles allowed from last tap write to fir_tap_done

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  0 = synchronous clear to SM_INIT
cfg_set  in  clog2(G_NUM_SETS)  coefficient set to load
cfg_valid  in  1  load request
cfg_ready  out  1  request accepted when cfg_valid&&cfg_ready
busy  out  1  high in any state except SM_INIT/SM_RUN
loaded  out  1  a complete set is active in the FIR
active_set  out  clog2(G_NUM_SETS)  set currently loaded
error  out  1  sticky; done timeout occurred
coef_rd_addr  out  clog2(G_NUM_SETS*G_NUM_TAPS)  coefficient memory address
coef_rd_en  out  1  read strobe; data is valid the next cycle
coef_rd_data  in  G_TAP_WIDTH  read data
fir_enable  out  1  drives FIR enable
fir_tap_dout  out  G_TAP_WIDTH  tap value to FIR
fir_tap_valid  out  1  tap valid
fir_tap_ready  in  1  FIR tap ready
fir_tap_done  in  1  FIR reports all taps loaded
s_din_valid  in  1  upstream sample valid
s_din_ready  out  1  upstream sample ready
fir_din_valid  out  1  gated sample valid to FIR
fir_din_ready  in  1  FIR sample ready
fir_dout_valid  in  1  monitored FIR output valid
fir_dout_ready  in  1  monitored FIR output ready

Behaviour:
- Reset:
  - state SM_INIT; tap_idx=0; inflight=0.
  - All outputs 0: fir_enable, loaded, active_set, error, coef_rd_en, fir_tap_valid.
  - cfg_ready=1 only once in SM_INIT (combinational).
- enable=0: same clear as reset, except error is retained. fir_enable=0.
- fir_enable=1 in every state except SM_INIT and SM_FLUSH.
- Sample gating (combinational):
  - open = (state==SM_RUN) && (inflight<G_MAX_INFLIGHT).
  - fir_din_valid = s_din_valid&&open; s_din_ready = fir_din_ready&&open.
- inflight counter:
  - +1 on fir_din_valid&&fir_din_ready; -1 on fir_dout_valid&&fir_dout_ready.
  - Both in the same cycle: no change.
  - Never wraps; decrement at 0 is ignored (verification asserts it never occurs).
- cfg_ready=1 only in SM_INIT and SM_RUN.
- States and transitions:
  - SM_INIT: no taps loaded. Accepted cfg latches cfg_set -> SM_FLUSH.
  - SM_RUN: loaded=1. Accepted cfg latches set, clears loaded -> SM_DRAIN. Sample gate closes the same cycle as acceptance.
  - SM_DRAIN: waits until inflight==0 -> SM_FLUSH. If inflight is already 0, one cycle is spent here.
  - SM_FLUSH: exactly one cycle with fir_enable=0, resetting the FIR tap pointer; tap_idx=0 -> SM_LOAD_RD.
  - SM_LOAD_RD: one cycle. coef_rd_en=1, coef_rd_addr = set*G_NUM_TAPS + tap_idx -> SM_LOAD_WR.
  - SM_LOAD_WR:
    - On entry, capture coef_rd_data into the tap register.
    - Hold fir_tap_valid=1 with the tap register stable until fir_tap_ready.
    - On handshake: if tap_idx==G_NUM_TAPS-1 -> SM_WAIT_DONE (timer=0); else tap_idx+1 -> SM_LOAD_RD.
  - SM_WAIT_DONE:
    - fir_tap_done=1 -> SM_RUN, loaded=1, active_set=latched set.
    - Timer reaching G_DONE_TIMEOUT -> error=1, SM_INIT.
- Per-tap cost is 2 cycles minimum.
- Minimum reload time from SM_INIT is 1 + 2*G_NUM_TAPS + 1 cycles plus done latency.
- cfg_set >= G_NUM_SETS is accepted, but the set index is taken modulo G_NUM_SETS.
- Reset asserted mid-load: immediate return to SM_INIT. Partially loaded taps are discarded logically (loaded=0).

Decomposition:
- Shared package tiny_fir_pkg holds:
  - state_t enum (SM_INIT, SM_RUN, SM_DRAIN, SM_FLUSH, SM_LOAD_RD, SM_LOAD_WR, SM_WAIT_DONE).
  - Address-width helper constant functions.
- One sub-module: tiny_fir_inflight_counter (saturating up/down counter, parameter G_MAX, exposes count and at_max).

Test Plan:
- Reset then cfg_set=2: coef reads at addr 32..47 in order, one fir_tap_valid per tap, exactly one fir_enable=0 cycle before the first tap. fir_tap_done -> loaded=1, active_set=2.
- fir_tap_ready toggling 1/0 randomly during load: fir_tap_dout stable while valid&&!ready, 16 handshakes total, no duplicates.
- Load while running with 3 samples in flight: s_din_ready=0 from the acceptance cycle. FIR returns 3 outputs, then the flush cycle, then the reload of set 1.
- Running with dout stalled: after 4 accepted samples, s_din_ready=0. One output accepted -> the gate reopens. Simultaneous in/out keeps inflight=4.
- fir_tap_done never asserted: error=1 exactly 64 cycles after the last tap handshake, state SM_INIT, cfg_ready=1, error persists through enable=0.
- reset asserted at tap_idx=7: next cycle all outputs 0. A new cfg reloads from tap 0.

Source files
------------

// File: rtl/tiny_fir_pkg.sv
// tiny_fir_pkg: sequencer state encoding and address/width helper functions
package tiny_fir_pkg;
  typedef enum logic [2:0] {
    SM_INIT, SM_RUN, SM_DRAIN, SM_FLUSH, SM_LOAD_RD, SM_LOAD_WR, SM_WAIT_DONE
  } state_t;
  function automatic int f_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int f_addr_w(input int sets, input int taps);
    return f_w(sets * taps);
  endfunction
endpackage

// File: rtl/tiny_fir_inflight_counter.sv
// tiny_fir_inflight_counter: saturating up/down count of samples held in the FIR (clk, reset, i_clr/i_inc/i_dec in; o_count, o_at_max out)
module tiny_fir_inflight_counter
  import tiny_fir_pkg::*;
#(
  parameter int G_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr,
  input  logic                    i_inc,
  input  logic                    i_dec,
  output logic [f_w(G_MAX+1)-1:0] o_count,
  output logic                    o_at_max
);
  localparam int C_W = f_w(G_MAX + 1);
  logic [C_W-1:0] r_count;
  assign o_count  = r_count;
  assign o_at_max = r_count == C_W'(G_MAX);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_inc && !i_dec && !o_at_max) r_count <= r_count + 1'b1;
    else if (i_dec && !i_inc && r_count != '0) r_count <= r_count - 1'b1;
endmodule

// File: rtl/tiny_fir_tap_sequencer.sv
// tiny_fir_tap_sequencer: loads coefficient sets into a tiny_fir and gates its sample stream (cfg in, coef memory read, FIR tap/sample/enable control out)
module tiny_fir_tap_sequencer
  import tiny_fir_pkg::*;
#(
  parameter int G_NUM_TAPS     = 16,
  parameter int G_TAP_WIDTH    = 16,
  parameter int G_NUM_SETS     = 4,
  parameter int G_MAX_INFLIGHT = 4,
  parameter int G_DONE_TIMEOUT = 64
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic [f_w(G_NUM_SETS)-1:0]                  cfg_set,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  output logic                                        busy,
  output logic                                        loaded,
  output logic [f_w(G_NUM_SETS)-1:0]                  active_set,
  output logic                                        error,
  output logic [f_addr_w(G_NUM_SETS,G_NUM_TAPS)-1:0]  coef_rd_addr,
  output logic                                        coef_rd_en,
  input  logic [G_TAP_WIDTH-1:0]                      coef_rd_data,
  output logic                                        fir_enable,
  output logic [G_TAP_WIDTH-1:0]                      fir_tap_dout,
  output logic                                        fir_tap_valid,
  input  logic                                        fir_tap_ready,
  input  logic                                        fir_tap_done,
  input  logic                                        s_din_valid,
  output logic                                        s_din_ready,
  output logic                                        fir_din_valid,
  input  logic                                        fir_din_ready,
  input  logic                                        fir_dout_valid,
  input  logic                                        fir_dout_ready
);
  localparam int C_SW = f_w(G_NUM_SETS);
  localparam int C_AW = f_addr_w(G_NUM_SETS, G_NUM_TAPS);
  localparam int C_TW = f_w(G_NUM_TAPS);
  localparam int C_DW = f_w(G_DONE_TIMEOUT);
  localparam int C_IW = f_w(G_MAX_INFLIGHT + 1);
  state_t            r_state, w_nxt;
  logic [C_SW-1:0]   r_set, r_active_set;
  logic [C_TW-1:0]   r_tap_idx;
  logic [C_DW-1:0]   r_timer;
  logic [G_TAP_WIDTH-1:0] r_tap;
  logic              r_loaded, r_error, r_rd_d;
  logic [C_IW-1:0]   w_cnt;
  logic              w_at_max, w_acc, w_open, w_hs, w_last, w_done, w_tmo;
  assign cfg_ready     = enable && (r_state == SM_INIT || r_state == SM_RUN);
  assign w_acc         = cfg_valid && cfg_ready;
  assign w_open        = enable && r_state == SM_RUN && !w_at_max && !w_acc;
  assign fir_din_valid = s_din_valid && w_open;
  assign s_din_ready   = fir_din_ready && w_open;
  assign busy          = r_state != SM_INIT && r_state != SM_RUN;
  assign fir_enable    = r_state != SM_INIT && r_state != SM_FLUSH;
  assign loaded        = r_loaded;
  assign active_set    = r_active_set;
  assign error         = r_error;
  assign coef_rd_en    = r_state == SM_LOAD_RD;
  assign coef_rd_addr  = coef_rd_en ? C_AW'(r_set) * C_AW'(G_NUM_TAPS) + C_AW'(r_tap_idx) : '0;
  assign fir_tap_valid = r_state == SM_LOAD_WR;
  // the read data only arrives in the first write cycle, so it bypasses the tap register there
  assign fir_tap_dout  = r_rd_d ? coef_rd_data : r_tap;
  assign w_hs          = fir_tap_valid && fir_tap_ready;
  assign w_last        = r_tap_idx == C_TW'(G_NUM_TAPS - 1);
  assign w_done        = r_state == SM_WAIT_DONE && fir_tap_done;
  assign w_tmo         = r_state == SM_WAIT_DONE && !fir_tap_done && r_timer == C_DW'(G_DONE_TIMEOUT - 1);
  tiny_fir_inflight_counter #(.G_MAX(G_MAX_INFLIGHT)) u_inflight (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (!enable),
    .i_inc    (fir_din_valid && fir_din_ready),
    .i_dec    (fir_dout_valid && fir_dout_ready),
    .o_count  (w_cnt),
    .o_at_max (w_at_max)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= SM_INIT;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      SM_INIT:      if (w_acc) w_nxt = SM_FLUSH;
      SM_RUN:       if (w_acc) w_nxt = SM_DRAIN;
      SM_DRAIN:     if (w_cnt == '0) w_nxt = SM_FLUSH;
      SM_FLUSH:     w_nxt = SM_LOAD_RD;
      SM_LOAD_RD:   w_nxt = SM_LOAD_WR;
      SM_LOAD_WR:   if (w_hs) w_nxt = w_last ? SM_WAIT_DONE : SM_LOAD_RD;
      SM_WAIT_DONE: w_nxt = w_done ? SM_RUN : w_tmo ? SM_INIT : SM_WAIT_DONE;
      default:      w_nxt = SM_INIT;
    endcase
    if (!enable) w_nxt = SM_INIT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_error <= 1'b0;
    else if (enable && w_tmo) r_error <= 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_set        <= '0;
      r_active_set <= '0;
      r_loaded     <= 1'b0;
      r_tap_idx    <= '0;
      r_tap        <= '0;
      r_rd_d       <= 1'b0;
      r_timer      <= '0;
    end else if (!enable) begin
      r_set        <= '0;
      r_active_set <= '0;
      r_loaded     <= 1'b0;
      r_tap_idx    <= '0;
      r_tap        <= '0;
      r_rd_d       <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_rd_d  <= coef_rd_en;
      r_timer <= (r_state == SM_WAIT_DONE) ? r_timer + 1'b1 : '0;
      if (r_rd_d) r_tap <= coef_rd_data;
      if (w_acc) r_set <= C_SW'(cfg_set % G_NUM_SETS);
      if (w_acc) r_loaded <= 1'b0;
      if (r_state == SM_FLUSH) r_tap_idx <= '0;
      else if (w_hs && !w_last) r_tap_idx <= r_tap_idx + 1'b1;
      if (w_done) begin
        r_loaded     <= 1'b1;
        r_active_set <= r_set;
      end
    end
  end
endmodule
